mem_lsu_stage: RTL
==================

# mem_lsu_stage

Pipeline MEM stage: the consumer side of the EX stage's valid/ready handshake. It captures one instruction from EX and, for loads and stores, runs a single data-bus transaction (req/gnt then rvalid). It produces the MEM-stage forwarding and CSR-hazard signals back to EX and presents the result to WB under a valid/ready handshake. Non-memory instructions pass through in one cycle.

## Interface
- XLEN, 32, datapath width (only 32 supported).

- clk  in  1  clock
- rst  in  1  reset rst, synchronous, active-high
- mem_flush_i  in  1  kill the instruction held in MEM
- EX_valid_i  in  1  EX offers an instruction
- MEM_ready_o  out  1  MEM accepts from EX this cycle
- MEM_valid_o  out  1  MEM result offered to WB
- WB_ready_i  in  1  WB accepts
- ex_pc_i  in  XLEN  instruction PC
- ex_result_i  in  XLEN  ALU result; effective address for loads/stores
- ex_store_data_i  in  XLEN  store data (rs2)
- ex_load_i, ex_store_i  in  1  memory op type (mutually exclusive)
- ex_size_i  in  2  0=byte, 1=half, 2=word
- ex_unsigned_i  in  1  zero-extend load
- ex_rd_wen_i / ex_rd_idx_i  in  1/5  destination register
- ex_csr_wen_i / ex_csr_idx_i  in  1/12  CSR write
- dbus_req_o, dbus_we_o  out  1  bus request, write enable
- dbus_addr_o  out  XLEN  word-aligned address ({addr[31:2],2'b00})
- dbus_wdata_o  out  XLEN  lane-replicated store data
- dbus_wstrb_o  out  4  byte strobes (0 for loads)
- dbus_gnt_i  in  1  request accepted
- dbus_rvalid_i, dbus_err_i  in  1  response, bus error
- dbus_rdata_i  in  XLEN  read data
- MEM_pc_o  out  XLEN
- MEM_rd_wen_o / MEM_rd_idx_o  out  1/5  to EX forwarding and WB
- MEM_fwd_data_o  out  XLEN  load data if load, else ex_result
- MEM_csr_wen_o / MEM_csr_idx_o  out  1/12  to EX CSR hazard detect
- MEM_ld_misalign_o, MEM_st_misalign_o, MEM_ld_bus_err_o, MEM_st_bus_err_o  out  1  exceptions

## Operation
- Holding register plus data_valid. Capture happens when MEM_ready_o && EX_valid_i. On MEM_ready_o with !EX_valid_i, data_valid becomes 0.
- All MEM_* payload outputs are ANDed with data_valid: they read 0 when empty.
- MEM_rd_wen_o is forced 0 when any exception flag is set.
- Misalignment: a half access needs addr[0]=0; a word access needs addr[1:0]=0. A misaligned access issues no bus request; it sets its flag and completes as DONE.
- FSM states: IDLE, REQ, WAIT, DONE, DRAIN.
  - On capture of an aligned load/store: go to REQ. On capture of anything else, or of a misaligned access: go to DONE.
  - REQ: dbus_req_o=1. On gnt, go to WAIT.
  - WAIT: on rvalid, latch rdata/err and go to DONE. Stores also wait for rvalid (write ack).
  - DONE: on MEM_valid_o && WB_ready_i, go to the next captured instruction's state, or to IDLE.
- busy = data_valid && state in {REQ, WAIT, DRAIN}.
- MEM_ready_o = !mem_flush_i && !busy && (!data_valid || WB_ready_i).
- MEM_valid_o = data_valid && state==DONE && !mem_flush_i.
- Store strobes:
  - byte: 4'b0001<<addr[1:0], wdata = {4{data[7:0]}}.
  - half: 4'b0011<<{addr[1],1'b0}, wdata = {2{data[15:0]}}.
  - word: 4'hF, wdata unchanged.
- Load extraction selects the lane by addr[1:0], then sign- or zero-extends per ex_unsigned_i.
- While busy, MEM_fwd_data_o is not yet valid. EX is stalled by MEM_ready_o=0, so it cannot consume the value.
- Flush handling:
  - In REQ with no gnt: go to IDLE, data_valid=0.
  - In REQ with gnt the same cycle, or in WAIT: go to DRAIN. DRAIN discards the response on rvalid, then goes to IDLE with data_valid=0.
  - In IDLE/DONE: data_valid=0 next cycle.
  - No capture occurs in a flush cycle.
- dbus_addr/we/wdata/wstrb stay stable while dbus_req_o=1.

## Timing
- Reset state: data_valid=0, state IDLE. All outputs are 0 except MEM_ready_o=1 (rst low, no flush, WB ready).
- Non-memory instruction captured at edge T: MEM_valid_o=1 in cycle T.
- Load/store captured at edge T with gnt in cycle T and rvalid in T+1: MEM_valid_o=1 in T+2. Each gnt or rvalid wait cycle adds one cycle.
- Throughput: 1/cycle for non-memory ops; a new capture is allowed in the same cycle WB accepts from DONE.
- rvalid arrives no earlier than the cycle after gnt. dbus_err_i is sampled only with rvalid.

## Test plan
- ADD result 0x1234, rd=5, WB_ready=1 -> MEM_valid_o, MEM_rd_idx_o=5, MEM_fwd_data_o=0x1234 in the cycle after capture; back-to-back issue gives 1/cycle.
- LB addr 0x103, rdata 0x80AABBCC, gnt delayed 2 cycles -> addr 0x100, wstrb 0, result 0xFFFFFF80 four cycles after capture; MEM_ready_o=0 throughout. LBU -> 0x00000080.
- SH addr 0x102, data 0x0000BEEF -> wstrb 4'b1100, wdata 0xBEEFBEEF, we=1, MEM_rd_wen_o=0.
- LW addr 0x101 -> no dbus_req_o; MEM_ld_misalign_o=1 and MEM_rd_wen_o=0 next cycle. SW with dbus_err_i on rvalid -> MEM_st_bus_err_o=1.
- Flush in WAIT -> DRAIN. rvalid 3 cycles later is discarded, MEM_valid_o never rises, MEM_ready_o returns to 1 the cycle after rvalid.
- WB_ready_i=0 for 3 cycles at DONE -> outputs held stable, MEM_ready_o=0. Assert rst mid-REQ -> next cycle dbus_req_o=0 and all outputs 0.

Source files
------------

// File: rtl/mem_lsu_stage.sv
// MEM pipeline stage: captures one instruction from EX, runs at most one data-bus
// transaction for loads/stores, and hands the result to WB under valid/ready.
module mem_lsu_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mem_flush_i,
    input  logic            EX_valid_i,
    output logic            MEM_ready_o,
    output logic            MEM_valid_o,
    input  logic            WB_ready_i,
    input  logic [XLEN-1:0] ex_pc_i,
    input  logic [XLEN-1:0] ex_result_i,
    input  logic [XLEN-1:0] ex_store_data_i,
    input  logic            ex_load_i,
    input  logic            ex_store_i,
    input  logic [1:0]      ex_size_i,
    input  logic            ex_unsigned_i,
    input  logic            ex_rd_wen_i,
    input  logic [4:0]      ex_rd_idx_i,
    input  logic            ex_csr_wen_i,
    input  logic [11:0]     ex_csr_idx_i,
    output logic            dbus_req_o,
    output logic            dbus_we_o,
    output logic [XLEN-1:0] dbus_addr_o,
    output logic [XLEN-1:0] dbus_wdata_o,
    output logic [3:0]      dbus_wstrb_o,
    input  logic            dbus_gnt_i,
    input  logic            dbus_rvalid_i,
    input  logic            dbus_err_i,
    input  logic [XLEN-1:0] dbus_rdata_i,
    output logic [XLEN-1:0] MEM_pc_o,
    output logic            MEM_rd_wen_o,
    output logic [4:0]      MEM_rd_idx_o,
    output logic [XLEN-1:0] MEM_fwd_data_o,
    output logic            MEM_csr_wen_o,
    output logic [11:0]     MEM_csr_idx_o,
    output logic            MEM_ld_misalign_o,
    output logic            MEM_st_misalign_o,
    output logic            MEM_ld_bus_err_o,
    output logic            MEM_st_bus_err_o
);

    // state | meaning
    // IDLE  | nothing held (or waiting for the next capture)
    // REQ   | dbus_req_o asserted, waiting for gnt
    // WAIT  | granted, waiting for rvalid (read data or write ack)
    // DONE  | result offered to WB
    // DRAIN | flushed after grant, swallowing the outstanding response
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_DONE  = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t state, state_nxt, cap_state;
    logic   data_valid, data_valid_nxt;

    logic [XLEN-1:0] pc_q, res_q, sdata_q, rdata_q;
    logic            load_q, store_q, uns_q, rd_wen_q, csr_wen_q;
    logic [1:0]      size_q;
    logic [4:0]      rd_idx_q;
    logic [11:0]     csr_idx_q;
    logic            ld_mis_q, st_mis_q, err_q;

    logic            ex_mem_op, ex_misalign;
    logic            busy, capture, wb_accept;
    logic            ld_err, st_err, any_exc;
    logic [XLEN-1:0] ld_shift, ld_data, st_wdata;
    logic [3:0]      st_wstrb;

    assign ex_mem_op   = ex_load_i | ex_store_i;
    assign ex_misalign = ex_mem_op &&
                         (((ex_size_i == 2'd1) && ex_result_i[0]) ||
                          ((ex_size_i == 2'd2) && (ex_result_i[1:0] != 2'b00)));
    assign cap_state   = (ex_mem_op && !ex_misalign) ? S_REQ : S_DONE;

    assign busy      = data_valid && ((state == S_REQ) || (state == S_WAIT) || (state == S_DRAIN));
    assign capture   = MEM_ready_o && EX_valid_i;
    assign wb_accept = MEM_valid_o && WB_ready_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            data_valid <= 1'b0;
        end else begin
            state      <= state_nxt;
            data_valid <= data_valid_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        data_valid_nxt = data_valid;
        if (mem_flush_i) begin
            // A granted request still owes us a response, so it must be drained.
            case (state)
                S_REQ: begin
                    if (dbus_gnt_i) begin
                        state_nxt = S_DRAIN;
                    end else begin
                        state_nxt      = S_IDLE;
                        data_valid_nxt = 1'b0;
                    end
                end
                S_WAIT: state_nxt = S_DRAIN;
                S_DRAIN: begin
                    if (dbus_rvalid_i) begin
                        state_nxt      = S_IDLE;
                        data_valid_nxt = 1'b0;
                    end
                end
                default: begin
                    state_nxt      = S_IDLE;
                    data_valid_nxt = 1'b0;
                end
            endcase
        end else begin
            case (state)
                S_IDLE: begin
                    if (capture) begin
                        state_nxt      = cap_state;
                        data_valid_nxt = 1'b1;
                    end else if (MEM_ready_o) begin
                        data_valid_nxt = 1'b0;
                    end
                end
                S_REQ: begin
                    if (dbus_gnt_i) state_nxt = S_WAIT;
                end
                S_WAIT: begin
                    if (dbus_rvalid_i) state_nxt = S_DONE;
                end
                S_DONE: begin
                    if (wb_accept) begin
                        if (capture) begin
                            state_nxt      = cap_state;
                            data_valid_nxt = 1'b1;
                        end else begin
                            state_nxt      = S_IDLE;
                            data_valid_nxt = 1'b0;
                        end
                    end
                end
                S_DRAIN: begin
                    if (dbus_rvalid_i) begin
                        state_nxt      = S_IDLE;
                        data_valid_nxt = 1'b0;
                    end
                end
                default: begin
                    state_nxt      = S_IDLE;
                    data_valid_nxt = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q      <= '0;
            res_q     <= '0;
            sdata_q   <= '0;
            rdata_q   <= '0;
            load_q    <= 1'b0;
            store_q   <= 1'b0;
            uns_q     <= 1'b0;
            size_q    <= 2'd0;
            rd_wen_q  <= 1'b0;
            rd_idx_q  <= 5'd0;
            csr_wen_q <= 1'b0;
            csr_idx_q <= 12'd0;
            ld_mis_q  <= 1'b0;
            st_mis_q  <= 1'b0;
            err_q     <= 1'b0;
        end else if (capture) begin
            pc_q      <= ex_pc_i;
            res_q     <= ex_result_i;
            sdata_q   <= ex_store_data_i;
            rdata_q   <= '0;
            load_q    <= ex_load_i;
            store_q   <= ex_store_i;
            uns_q     <= ex_unsigned_i;
            size_q    <= ex_size_i;
            rd_wen_q  <= ex_rd_wen_i;
            rd_idx_q  <= ex_rd_idx_i;
            csr_wen_q <= ex_csr_wen_i;
            csr_idx_q <= ex_csr_idx_i;
            ld_mis_q  <= ex_load_i && ex_misalign;
            st_mis_q  <= ex_store_i && ex_misalign;
            err_q     <= 1'b0;
        end else if ((state == S_WAIT) && dbus_rvalid_i && !mem_flush_i) begin
            rdata_q <= dbus_rdata_i;
            err_q   <= dbus_err_i;
        end
    end

    // Lane select by byte offset; the half case is aligned so the same shift works.
    assign ld_shift = rdata_q >> {res_q[1:0], 3'b000};

    always_comb begin
        ld_data  = rdata_q;
        st_wdata = sdata_q;
        st_wstrb = 4'hF;
        case (size_q)
            2'd0: begin
                ld_data  = {{24{~uns_q & ld_shift[7]}}, ld_shift[7:0]};
                st_wdata = {4{sdata_q[7:0]}};
                st_wstrb = 4'b0001 << res_q[1:0];
            end
            2'd1: begin
                ld_data  = {{16{~uns_q & ld_shift[15]}}, ld_shift[15:0]};
                st_wdata = {2{sdata_q[15:0]}};
                st_wstrb = 4'b0011 << {res_q[1], 1'b0};
            end
            default: begin
                ld_data  = rdata_q;
                st_wdata = sdata_q;
                st_wstrb = 4'hF;
            end
        endcase
    end

    assign ld_err  = load_q & err_q;
    assign st_err  = store_q & err_q;
    assign any_exc = ld_mis_q | st_mis_q | ld_err | st_err;

    always_comb begin
        MEM_ready_o = !mem_flush_i && !busy && (!data_valid || WB_ready_i);
        MEM_valid_o = data_valid && (state == S_DONE) && !mem_flush_i;

        dbus_req_o   = data_valid && (state == S_REQ);
        dbus_we_o    = dbus_req_o && store_q;
        dbus_addr_o  = dbus_req_o ? {res_q[XLEN-1:2], 2'b00} : '0;
        dbus_wdata_o = (dbus_req_o && store_q) ? st_wdata : '0;
        dbus_wstrb_o = (dbus_req_o && store_q) ? st_wstrb : 4'h0;

        MEM_pc_o          = data_valid ? pc_q : '0;
        MEM_rd_wen_o      = data_valid && rd_wen_q && !any_exc;
        MEM_rd_idx_o      = data_valid ? rd_idx_q : 5'd0;
        MEM_fwd_data_o    = data_valid ? (load_q ? ld_data : res_q) : '0;
        MEM_csr_wen_o     = data_valid && csr_wen_q;
        MEM_csr_idx_o     = data_valid ? csr_idx_q : 12'd0;
        MEM_ld_misalign_o = data_valid && ld_mis_q;
        MEM_st_misalign_o = data_valid && st_mis_q;
        MEM_ld_bus_err_o  = data_valid && ld_err;
        MEM_st_bus_err_o  = data_valid && st_err;
    end

endmodule
